// File: rtl/bloom_filter_prog.sv
// Programmable bloom filter: a sweep-cleared MEM_DEPTH-bit array filled by inserts, answering NUM_HASH-way membership queries.
// Latency: query result 1 cycle after accept; a clear sweep takes MEM_DEPTH/CLR_W cycles.
// Backpressure: q_ready_o/ins_ready_o low while clearing; no result backpressure. Define BLOOM_STATS_EN for query/hit/insert counters.
module bloom_filter_prog #(
  parameter int NUM_HASH  = 9,
  parameter int HASH_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int CLR_W     = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       clr_i,
  output logic                       busy_o,
  input  logic                       q_valid_i,
  output logic                       q_ready_o,
  input  logic [NUM_HASH*HASH_W-1:0] q_hash_i,
  output logic                       match_valid_o,
  output logic                       match_o,
  input  logic                       ins_valid_i,
  output logic                       ins_ready_o,
  input  logic [NUM_HASH*HASH_W-1:0] ins_hash_i
`ifdef BLOOM_STATS_EN
  ,
  output logic [31:0]                stat_q_o,
  output logic [31:0]                stat_hit_o,
  output logic [31:0]                stat_ins_o
`endif
);

  localparam int NCHUNK = MEM_DEPTH / CLR_W;
  localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [MEM_DEPTH-1:0] mem_q, mem_d;
  logic                 match_q, match_d;
  logic                 match_valid_q;
  logic                 hit;
  logic                 q_acc, ins_acc;
  logic [IDX_W-1:0]     clr_base;

  assign q_acc    = q_valid_i & q_ready_o;
  assign ins_acc  = ins_valid_i & ins_ready_o;
  assign clr_base = IDX_W'(int'(ptr_q) * CLR_W);

  // Sweep/run FSM: next state, sweep pointer and the ready/busy outputs.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    busy_o      = 1'b0;
    q_ready_o   = 1'b0;
    ins_ready_o = 1'b0;
    case (state_q)
      ST_CLEAR: begin
        busy_o = 1'b1;
        if (ptr_q == PTR_W'(NCHUNK - 1)) begin
          state_d = ST_RUN;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      default: begin
        q_ready_o   = 1'b1;
        ins_ready_o = 1'b1;
        if (clr_i) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
    endcase
  end

  // Array datapath: query reads the old contents, inserts set bits, the sweep zeroes one chunk.
  always_comb begin
    mem_d = mem_q;
    hit   = 1'b1;
    for (int k = 0; k < NUM_HASH; k++) begin
      if (int'(q_hash_i[k*HASH_W +: HASH_W]) >= MEM_DEPTH) begin
        hit = 1'b0;
      end else if (!mem_q[q_hash_i[k*HASH_W +: IDX_W]]) begin
        hit = 1'b0;
      end
    end
    if (ins_acc) begin
      for (int k = 0; k < NUM_HASH; k++) begin
        if (int'(ins_hash_i[k*HASH_W +: HASH_W]) < MEM_DEPTH) begin
          mem_d[ins_hash_i[k*HASH_W +: IDX_W]] = 1'b1;
        end
      end
    end
    if (state_q == ST_CLEAR) begin
      mem_d[clr_base +: CLR_W] = '0;
    end
    match_d = q_acc ? hit : match_q;
  end

  // Control and result registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ST_CLEAR;
      ptr_q         <= '0;
      match_valid_q <= 1'b0;
      match_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      match_valid_q <= q_acc;
      match_q       <= match_d;
    end
  end

  // Membership array: no reset, the sweep that follows every reset zeroes it.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign match_valid_o = match_valid_q;
  assign match_o       = match_q;

`ifdef BLOOM_STATS_EN
  logic        clr_acc;
  logic [31:0] stat_q_q, stat_hit_q, stat_ins_q;

  assign clr_acc = clr_i & (state_q == ST_RUN);

  // Saturating activity counters, zeroed by reset and by an accepted clear.
  always_ff @(posedge clk_i) begin
    if (!rst_ni || clr_acc) begin
      stat_q_q   <= '0;
      stat_hit_q <= '0;
      stat_ins_q <= '0;
    end else begin
      if (q_acc && stat_q_q != 32'hFFFF_FFFF) stat_q_q <= stat_q_q + 32'd1;
      if (match_valid_q && match_q && stat_hit_q != 32'hFFFF_FFFF) stat_hit_q <= stat_hit_q + 32'd1;
      if (ins_acc && stat_ins_q != 32'hFFFF_FFFF) stat_ins_q <= stat_ins_q + 32'd1;
    end
  end

  assign stat_q_o   = stat_q_q;
  assign stat_hit_o = stat_hit_q;
  assign stat_ins_o = stat_ins_q;
`endif

endmodule
